// File: rtl/seq_div8.sv
// Sequential restoring divider: unsigned quotient/remainder in WIDTH steps.
// Ports: clk, rst (async, active-high), start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero.
module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic             w_last;
  logic             w_dz;

  // Partial remainder stays below the divisor, so the shifted value
  // needs one extra bit and the borrow of the trial subtract decides.
  assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_d};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_q_nx   = {r_q[WIDTH-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(1));
  assign w_dz     = (divisor == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_dz ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem <= '0;
            r_q   <= dividend;
            r_d   <= divisor;
            r_cnt <= CW'(WIDTH);
            r_dbz <= 1'b0;
            if (w_dz) begin
              r_quot <= '1;
              r_remo <= dividend;
              r_dbz  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt - CW'(1);
          // Results are published only on the final step.
          if (w_last) begin
            r_quot <= w_q_nx;
            r_remo <= w_rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div8.sv
// Directed and randomised checks for seq_div8.
// Drives ops on the falling edge, samples outputs on the falling edge.
module tb_seq_div8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_run;
  int n_fail;

  seq_div8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcyc);
    bit seen;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcyc = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk("op_done_seen", 32'(seen), 1);
  endtask

  int lat;
  int bc;
  int ndone;
  logic [7:0] corner [4];
  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] eq;
  logic [7:0] er;
  logic       ez;

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    corner[0] = 8'd0;
    corner[1] = 8'd1;
    corner[2] = 8'd254;
    corner[3] = 8'd255;

    repeat (2) @(negedge clk);
    chk("rst_state", {busy, done, div_by_zero, quotient, remainder}, 0);
    rst = 1'b0;

    // 1: 200/7
    run_op(8'd200, 8'd7, lat, bc);
    chk("t1_lat", lat, 9);
    chk("t1_busy", bc, 9);
    chk("t1_q", quotient, 28);
    chk("t1_r", remainder, 4);
    chk("t1_dbz", div_by_zero, 0);
    @(negedge clk);
    chk("t1_pulse", {busy, done}, 0);
    chk("t1_hold", {quotient, remainder}, {8'd28, 8'd4});

    // 2: corners
    run_op(8'd255, 8'd1, lat, bc);
    chk("t2a_qr", {quotient, remainder}, {8'd255, 8'd0});
    run_op(8'd5, 8'd10, lat, bc);
    chk("t2b_qr", {quotient, remainder}, {8'd0, 8'd5});

    // 3: divide by zero, then flag clears
    run_op(8'd37, 8'd0, lat, bc);
    chk("t3_lat", lat, 1);
    chk("t3_qr", {quotient, remainder}, {8'd255, 8'd37});
    chk("t3_dbz", div_by_zero, 1);
    run_op(8'd10, 8'd3, lat, bc);
    chk("t3b_lat", lat, 9);
    chk("t3b_res", {div_by_zero, quotient, remainder}, {1'b0, 8'd3, 8'd1});

    // 4: start held during RUN is ignored
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd9;
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    repeat (5) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_ndone", ndone, 1);
    chk("t4_qr", {quotient, remainder}, {8'd11, 8'd1});

    // 5: async reset mid-RUN
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst", {busy, done, div_by_zero, quotient, remainder}, 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_nodone", ndone, 0);
    run_op(8'd200, 8'd7, lat, bc);
    chk("t5_lat", lat, 9);
    chk("t5_qr", {quotient, remainder}, {8'd28, 8'd4});

    // 6: back-to-back ops against / and %
    for (int i = 0; i < 1000; i++) begin
      if (i < 16) begin
        ra = corner[i % 4];
        rb = corner[i / 4];
      end else begin
        ra = 8'($urandom_range(255));
        rb = 8'($urandom_range(255));
      end
      if (rb == 0) begin
        eq = 8'd255;
        er = ra;
        ez = 1'b1;
      end else begin
        eq = ra / rb;
        er = ra % rb;
        ez = 1'b0;
      end
      run_op(ra, rb, lat, bc);
      chk("t6_res", {div_by_zero, quotient, remainder}, {ez, eq, er});
      chk("t6_lat", lat, (rb == 0) ? 1 : 9);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
